// File: rtl/cs_mir_pipe.sv
// Microinstruction register: latches control-store words and slices them into datapath control fields.
// Latency: an accepted word reaches the field outputs the following cycle; full rate while unstalled.
// Backpressure: SKID_EN=1 keeps a registered ready that drops only when both entries hold; SKID_EN=0 passes ready through.
module cs_mir_pipe #(
    parameter int REG_W   = 6,
    parameter int ALU_W   = 4,
    parameter int COND_W  = 3,
    parameter int ADDR_W  = 11,
    parameter int SKID_EN = 1,
    parameter int CNT_W   = 16,
    localparam int INSTR_W = 3*REG_W + 5 + ALU_W + COND_W + ADDR_W
) (
    input  logic                CS_MIR_CLOCK_50,
    input  logic                CS_MIR_RESET_InHigh,
    input  logic                CS_MIR_clear_InLow,
    input  logic [INSTR_W-1:0]  CS_MIR_INSTRUCTION_data_InBUS,
    input  logic                CS_MIR_INSTRUCTION_valid_In,
    output logic                CS_MIR_INSTRUCTION_ready_Out,
    input  logic                CS_MIR_ready_In,
    output logic                CS_MIR_valid_Out,
    output logic [REG_W-1:0]    CS_MIR_A_data_OutBUS,
    output logic                CS_MIR_AMUX_data_Out,
    output logic [REG_W-1:0]    CS_MIR_B_data_OutBUS,
    output logic                CS_MIR_BMUX_data_Out,
    output logic [REG_W-1:0]    CS_MIR_C_data_OutBUS,
    output logic                CS_MIR_CMUX_data_Out,
    output logic                CS_MIR_RD_data_Out,
    output logic                CS_MIR_WR_data_Out,
    output logic [ALU_W-1:0]    CS_MIR_ALU_data_OutBUS,
    output logic [COND_W-1:0]   CS_MIR_COND_data_OutBUS,
    output logic [ADDR_W-1:0]   CS_MIR_ADDRESS_data_OutBUS,
    output logic [CNT_W-1:0]    CS_MIR_STALL_count_OutBUS
);

    typedef struct packed {
        logic [REG_W-1:0]  a;
        logic              amux;
        logic [REG_W-1:0]  b;
        logic              bmux;
        logic [REG_W-1:0]  c;
        logic              cmux;
        logic              rd;
        logic              wr;
        logic [ALU_W-1:0]  alu;
        logic [COND_W-1:0] cond;
        logic [ADDR_W-1:0] addr;
    } mir_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t             state;
    logic [INSTR_W-1:0] main_q;
    logic [INSTR_W-1:0] skid_q;
    logic               rdy_q;
    logic [CNT_W-1:0]   stall_q;
    logic               valid;
    logic               ready;
    logic               accept;
    logic               transfer;
    mir_t               mir;

    assign valid    = (state != ST_EMPTY);
    assign ready    = (SKID_EN != 0) ? rdy_q : (~valid | CS_MIR_ready_In);
    assign accept   = CS_MIR_INSTRUCTION_valid_In & ready;
    assign transfer = valid & CS_MIR_ready_In;

    // Without a skid entry, ONE with accept but no transfer cannot occur, so FULL is unreachable.
    always_ff @(posedge CS_MIR_CLOCK_50) begin
        if (CS_MIR_RESET_InHigh) begin
            state   <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            rdy_q   <= 1'b1;
            stall_q <= '0;
        end else if (!CS_MIR_clear_InLow) begin
            state <= ST_EMPTY;
            rdy_q <= 1'b1;
        end else begin
            if (valid && !CS_MIR_ready_In && (stall_q != '1))
                stall_q <= stall_q + 1'b1;
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state  <= ST_ONE;
                        main_q <= CS_MIR_INSTRUCTION_data_InBUS;
                    end
                end
                ST_ONE: begin
                    if (accept && transfer) begin
                        main_q <= CS_MIR_INSTRUCTION_data_InBUS;
                    end else if (accept) begin
                        state  <= ST_FULL;
                        skid_q <= CS_MIR_INSTRUCTION_data_InBUS;
                        rdy_q  <= 1'b0;
                    end else if (transfer) begin
                        state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (transfer) begin
                        state  <= ST_ONE;
                        main_q <= skid_q;
                        rdy_q  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_EMPTY;
                    rdy_q <= 1'b1;
                end
            endcase
        end
    end

    // An empty register presents an all-zero NOP on every field.
    assign mir = valid ? main_q : '0;

    assign CS_MIR_INSTRUCTION_ready_Out = ready;
    assign CS_MIR_valid_Out             = valid;
    assign CS_MIR_A_data_OutBUS         = mir.a;
    assign CS_MIR_AMUX_data_Out         = mir.amux;
    assign CS_MIR_B_data_OutBUS         = mir.b;
    assign CS_MIR_BMUX_data_Out         = mir.bmux;
    assign CS_MIR_C_data_OutBUS         = mir.c;
    assign CS_MIR_CMUX_data_Out         = mir.cmux;
    assign CS_MIR_RD_data_Out           = mir.rd;
    assign CS_MIR_WR_data_Out           = mir.wr;
    assign CS_MIR_ALU_data_OutBUS       = mir.alu;
    assign CS_MIR_COND_data_OutBUS      = mir.cond;
    assign CS_MIR_ADDRESS_data_OutBUS   = mir.addr;
    assign CS_MIR_STALL_count_OutBUS    = stall_q;

endmodule
